// File: rtl/dual_issue_if.sv
// Decode-slot bundle between DecodeStage and the issue scheduler.
// Per slot s (bit/index 0 = older slot): valid, source/destination indices,
// use/write enables, memory and control-flow class; issue_o returns the
// per-slot issue strobe that advances decode and loads IdExReg.
interface dual_issue_if;
  logic [1:0]      valid_i;
  logic [1:0][4:0] rs1_i;
  logic [1:0][4:0] rs2_i;
  logic [1:0]      use_rs1_i;
  logic [1:0]      use_rs2_i;
  logic [1:0][4:0] rd_i;
  logic [1:0]      rd_we_i;
  logic [1:0]      mem_i;
  logic [1:0]      ctrl_i;
  logic [1:0]      issue_o;

  modport master (
    output valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, rd_we_i, mem_i, ctrl_i,
    input  issue_o
  );

  modport slave (
    input  valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, rd_we_i, mem_i, ctrl_i,
    output issue_o
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Issue controller for the 2-wide in-order pipeline.
// Holds a per-register busy scoreboard, blocks RAW/WAW hazards against
// in-flight writers and between the two decode slots, limits issue to one
// memory op per cycle and nothing in slot 1 behind a control-flow op.
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   dec                decode-slot bundle (slave side), issue_o is combinational
//   ex_stall_i         downstream cannot accept, nothing issues
//   flush_i            decode slots killed this cycle, scoreboard kept
//   wb_we_i, wb_rd_i   two writeback lanes clearing busy bits
//   busy_o             registered scoreboard
//   stall_cycles_o     saturating count of cycles slot 0 was valid, unflushed, not issued
//   dual_cycles_o      saturating count of dual-issue cycles
module dual_issue_scheduler #(
  parameter int NumRegs  = 32,
  parameter int CntWidth = 32
) (
  input  logic                clk,
  input  logic                reset,
  dual_issue_if.slave         dec,
  input  logic                ex_stall_i,
  input  logic                flush_i,
  input  logic [1:0]          wb_we_i,
  input  logic [1:0][4:0]     wb_rd_i,
  output logic [NumRegs-1:0]  busy_o,
  output logic [CntWidth-1:0] stall_cycles_o,
  output logic [CntWidth-1:0] dual_cycles_o
);

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] eb;
  logic [NumRegs-1:0] busy_nxt;
  logic [1:0]         hz;
  logic               ph;
  logic [1:0]         issue;

  // Registers retiring this cycle count as free: forwarding supplies them.
  always_comb begin
    eb = busy_q;
    for (int l = 0; l < 2; l++) begin
      if (wb_we_i[l]) eb[wb_rd_i[l]] = 1'b0;
    end
    eb[0] = 1'b0;
  end

  always_comb begin
    hz = 2'b00;
    for (int s = 0; s < 2; s++) begin
      hz[s] = (dec.use_rs1_i[s] & eb[dec.rs1_i[s]]) |
              (dec.use_rs2_i[s] & eb[dec.rs2_i[s]]) |
              (dec.rd_we_i[s] & (dec.rd_i[s] != 5'd0) & eb[dec.rd_i[s]]);
    end
  end

  // Intra-pair hazards: slot 1 may only go if it is independent of slot 0.
  always_comb begin
    ph = dec.ctrl_i[0] | (dec.mem_i[0] & dec.mem_i[1]);
    if (dec.rd_we_i[0] && dec.rd_i[0] != 5'd0) begin
      if ((dec.use_rs1_i[1] && dec.rs1_i[1] == dec.rd_i[0]) ||
          (dec.use_rs2_i[1] && dec.rs2_i[1] == dec.rd_i[0]) ||
          (dec.rd_we_i[1] && dec.rd_i[1] == dec.rd_i[0]))
        ph = 1'b1;
    end
  end

  always_comb begin
    issue    = 2'b00;
    issue[0] = dec.valid_i[0] & ~flush_i & ~ex_stall_i & ~hz[0];
    issue[1] = issue[0] & dec.valid_i[1] & ~hz[1] & ~ph;
  end

  assign dec.issue_o = issue;

  // Clears first (already folded into eb), then sets, so set wins.
  always_comb begin
    busy_nxt = eb;
    for (int s = 0; s < 2; s++) begin
      if (issue[s] && dec.rd_we_i[s] && dec.rd_i[s] != 5'd0) busy_nxt[dec.rd_i[s]] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q         <= '0;
      stall_cycles_o <= '0;
      dual_cycles_o  <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (dec.valid_i[0] && !flush_i && !issue[0] && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 1'b1;
      if (issue[1] && dual_cycles_o != '1)
        dual_cycles_o <= dual_cycles_o + 1'b1;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
Issue controller for the 2-wide in-order pipeline. It sits between DecodeStage and IdExReg. It holds a register scoreboard (busy bit per architectural register), detects RAW/WAW hazards against in-flight writers and between the two decode slots, and enforces the structural limits: one memory op per cycle and no slot-1 issue behind a control-flow op. It drives per-slot issue strobes that advance decode and load IdExReg, and exports issue statistics.

Parameters:
NumRegs, 32, number of architectural registers; scoreboard depth; index width fixed at 5 bits.
CntWidth, 32, width of the statistics counters.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
valid_i  in  2  slot s holds a decoded instruction (bit 0 = older slot)
rs1_i  in  2x5  source 1 index per slot
rs2_i  in  2x5  source 2 index per slot
use_rs1_i  in  2  slot reads rs1
use_rs2_i  in  2  slot reads rs2
rd_i  in  2x5  destination index per slot
rd_we_i  in  2  slot writes rd
mem_i  in  2  slot is a load or store
ctrl_i  in  2  slot is a branch or jump
ex_stall_i  in  1  downstream cannot accept; no issue this cycle
flush_i  in  1  kill decode slots this cycle (mispredict)
wb_we_i  in  2  writeback lane l retires a register write
wb_rd_i  in  2x5  writeback destination per lane
issue_o  out  2  slot s issues this cycle (combinational)
busy_o  out  NumRegs  scoreboard state (registered)
stall_cycles_o  out  CntWidth  cycles with slot 0 valid but not issued
dual_cycles_o  out  CntWidth  cycles in which both slots issued

Behaviour:
- Reset: busy_o = 0, stall_cycles_o = 0, dual_cycles_o = 0. issue_o is combinational and is gated by busy = 0 during reset.
- Effective busy: eb[r] = busy[r] & ~(wb_we_i[0] & wb_rd_i[0]==r) & ~(wb_we_i[1] & wb_rd_i[1]==r). A register cleared this cycle counts as free, because the forwarding unit supplies the value.
- x0 is never busy. Writes to and clears of index 0 are ignored. Reads of x0 never hazard.
- Slot hazard hz[s]:
  - (use_rs1 & eb[rs1]), or
  - (use_rs2 & eb[rs2]), or
  - (rd_we & rd!=0 & eb[rd]), which is the WAW check against in-flight writers.
- Pair hazard ph is true when any of these holds:
  - ctrl_i[0];
  - mem_i[0] & mem_i[1];
  - rd_we_i[0] & rd_i[0]!=0 & ((use_rs1_i[1] & rs1_i[1]==rd_i[0]) | (use_rs2_i[1] & rs2_i[1]==rd_i[0]));
  - rd_we_i[0] & rd_we_i[1] & rd_i[0]==rd_i[1] & rd_i[0]!=0.
- issue_o[0] = valid_i[0] & ~flush_i & ~ex_stall_i & ~hz[0].
- issue_o[1] = issue_o[0] & valid_i[1] & ~hz[1] & ~ph. Issue is strictly in order: slot 1 never issues alone.
- Scoreboard update at posedge:
  - Clear busy[wb_rd_i[l]] for each wb_we_i[l].
  - Then set busy[rd_i[s]] for each issue_o[s] & rd_we_i[s] & rd_i[s]!=0.
  - Set wins over clear on the same index in the same cycle.
  - A clear of an already-free register has no effect. Both lanes clearing the same index is legal.
- Flush: suppresses issue only. The scoreboard is untouched, because in-flight writers still retire.
- ex_stall_i: suppresses issue. Writeback clears still apply.
- stall_cycles_o: +1 when valid_i[0] & ~flush_i & ~issue_o[0], including ex_stall_i cycles.
- dual_cycles_o: +1 when issue_o[1].
- Both counters saturate at all-ones and never wrap.
- Reset mid-operation: all state clears on the next edge. Writebacks pending at that moment are dropped.

Test Plan:
1. Reset held 2 cycles with valid_i=11 -> busy_o=0, stall_cycles_o=0, dual_cycles_o=0; after release, an independent pair issues.
2. Pair add x1,x0,x0 / add x2,x0,x0, no stalls -> issue_o=11; next cycle busy_o=0x6 and dual_cycles_o=1.
3. Slot 0 add x5 plus slot 1 sub x6,x5,x0 -> issue_o=01, busy[5]=1. Next cycle the re-presented sub sees busy x5 -> issue_o=00 and stall_cycles_o increments. In the cycle wb_we_i=01, wb_rd_i[0]=5 -> issue_o[0]=1.
4. Two loads (mem_i=11) -> issue_o=01. Branch in slot 0 (ctrl_i=01) with an independent slot 1 -> issue_o=01. Slot 1 WAW on x7 with slot 0 -> issue_o=01.
5. busy[9]=1, flush_i=1, valid_i=11 -> issue_o=00, busy_o unchanged, stall_cycles_o unchanged. With ex_stall_i=1 -> issue_o=00 and stall_cycles_o +1.
6. Same cycle wb clear of x3 and slot 0 issue writing x3 -> busy[3]=1 after the edge. rd=x0 with rd_we=1 -> busy[0] stays 0. Counter preloaded to all-ones by forcing -> holds at all-ones.
